// File: rtl/regfile_sb.sv
// Small register file with a write-back scoreboard: READ_AB reserves its destination
// until an external write-back returns, and later instructions stall on reserved registers.
module regfile_sb #(
    parameter int DATASIZE = 8,
    parameter int NREGS    = 4,
    parameter int ADDRW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [2:0]          op,
    input  logic [ADDRW-1:0]    sel_a,
    input  logic [ADDRW-1:0]    sel_b,
    input  logic [ADDRW-1:0]    sel_d,
    input  logic [DATASIZE-1:0] imm,
    input  logic                wb_valid,
    input  logic [ADDRW-1:0]    wb_addr,
    input  logic [DATASIZE-1:0] wb_data,
    output logic [DATASIZE-1:0] out_a,
    output logic [DATASIZE-1:0] out_b,
    output logic                out_valid,
    output logic [NREGS-1:0]    pending
);

    localparam logic [2:0] OP_READ_AB   = 3'd0;
    localparam logic [2:0] OP_LOAD      = 3'd1;
    localparam logic [2:0] OP_MOVE      = 3'd2;
    localparam logic [2:0] OP_CLEAR     = 3'd3;
    localparam logic [2:0] OP_CLEAR_ALL = 3'd4;

    function automatic logic [NREGS-1:0] onehot(input logic [ADDRW-1:0] addr);
        logic [NREGS-1:0] m;
        m       = '0;
        m[addr] = 1'b1;
        return m;
    endfunction

    logic [DATASIZE-1:0] regs_q [NREGS];
    logic [DATASIZE-1:0] regs_d [NREGS];
    logic [NREGS-1:0]    pending_q, pending_d;
    logic [DATASIZE-1:0] out_a_q, out_a_d;
    logic [DATASIZE-1:0] out_b_q, out_b_d;
    logic                out_valid_q, out_valid_d;

    logic [NREGS-1:0]    wb_mask;
    logic [NREGS-1:0]    busy;
    logic [NREGS-1:0]    use_mask;
    logic                fire;
    logic [DATASIZE-1:0] rd_a, rd_b;

    // A write-back landing this cycle releases its register for the instruction too.
    assign wb_mask = wb_valid ? onehot(wb_addr) : '0;
    assign busy    = pending_q & ~wb_mask;

    always_comb begin
        use_mask = '0;
        case (op)
            OP_READ_AB:         use_mask = onehot(sel_a) | onehot(sel_b) | onehot(sel_d);
            OP_LOAD, OP_CLEAR:  use_mask = onehot(sel_d);
            OP_MOVE:            use_mask = onehot(sel_a) | onehot(sel_d);
            OP_CLEAR_ALL:       use_mask = '1;
            default:            use_mask = '0;
        endcase
    end

    assign instr_ready = en && ((use_mask & busy) == '0);
    assign fire        = instr_valid && instr_ready;

    assign rd_a = (wb_valid && (wb_addr == sel_a)) ? wb_data : regs_q[sel_a];
    assign rd_b = (wb_valid && (wb_addr == sel_b)) ? wb_data : regs_q[sel_b];

    // Write-back is applied first so that a same-cycle instruction write overrides it.
    always_comb begin
        regs_d      = regs_q;
        pending_d   = pending_q & ~wb_mask;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_valid_d = 1'b0;
        if (wb_valid) begin
            regs_d[wb_addr] = wb_data;
        end
        if (fire) begin
            case (op)
                OP_READ_AB: begin
                    out_a_d          = rd_a;
                    out_b_d          = rd_b;
                    out_valid_d      = 1'b1;
                    pending_d[sel_d] = 1'b1;
                end
                OP_LOAD:  regs_d[sel_d] = imm;
                OP_MOVE:  regs_d[sel_d] = rd_a;
                OP_CLEAR: regs_d[sel_d] = '0;
                OP_CLEAR_ALL: begin
                    for (int i = 0; i < NREGS; i++) begin
                        regs_d[i] = '0;
                    end
                    pending_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q   <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            pending_q   <= pending_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model; a wide instance covers 16x16.
module tb_regfile_sb;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int AW = 2;

    localparam logic [2:0] RD  = 3'd0;
    localparam logic [2:0] LD  = 3'd1;
    localparam logic [2:0] MV  = 3'd2;
    localparam logic [2:0] CL  = 3'd3;
    localparam logic [2:0] CLA = 3'd4;
    localparam logic [2:0] NOP = 3'd7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, instr_valid, instr_ready, wb_valid, out_valid;
    logic [2:0]    op;
    logic [AW-1:0] sel_a, sel_b, sel_d, wb_addr;
    logic [DW-1:0] imm, wb_data, out_a, out_b;
    logic [NR-1:0] pending;

    logic        h_rst, h_en, h_iv, h_ready, h_wbv, h_ov;
    logic [2:0]  h_op;
    logic [3:0]  h_a, h_b, h_d, h_wba;
    logic [15:0] h_imm, h_wbd, h_oa, h_ob, h_pend;

    regfile_sb #(.DATASIZE(DW), .NREGS(NR), .ADDRW(AW)) dut (
        .clk(clk), .rst(rst), .en(en), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .sel_a(sel_a), .sel_b(sel_b), .sel_d(sel_d), .imm(imm),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_a(out_a), .out_b(out_b), .out_valid(out_valid), .pending(pending)
    );

    regfile_sb #(.DATASIZE(16), .NREGS(16), .ADDRW(4)) dut_wide (
        .clk(clk), .rst(h_rst), .en(h_en), .instr_valid(h_iv), .instr_ready(h_ready),
        .op(h_op), .sel_a(h_a), .sel_b(h_b), .sel_d(h_d), .imm(h_imm),
        .wb_valid(h_wbv), .wb_addr(h_wba), .wb_data(h_wbd),
        .out_a(h_oa), .out_b(h_ob), .out_valid(h_ov), .pending(h_pend)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the 8-bit x 4 instance.
    logic [DW-1:0] m_reg [NR];
    logic [DW-1:0] n_reg [NR];
    logic [NR-1:0] m_pend, n_pend;
    logic [DW-1:0] m_oa, m_ob, n_oa, n_ob;
    logic          m_ov, n_ov;

    function automatic logic [DW-1:0] m_read(input int a);
        if (wb_valid && int'(wb_addr) == a) return wb_data;
        return m_reg[a];
    endfunction

    function automatic bit m_ready();
        int touched[$];
        if (!en) return 1'b0;
        case (op)
            RD: begin
                touched.push_back(int'(sel_a));
                touched.push_back(int'(sel_b));
                touched.push_back(int'(sel_d));
            end
            LD, CL: touched.push_back(int'(sel_d));
            MV: begin
                touched.push_back(int'(sel_a));
                touched.push_back(int'(sel_d));
            end
            CLA: for (int i = 0; i < NR; i++) touched.push_back(i);
            default: ;
        endcase
        foreach (touched[k]) begin
            if (m_pend[touched[k]] && !(wb_valid && int'(wb_addr) == touched[k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Compare process: ready before each edge, registered outputs after it.
    initial begin
        bit rdy;
        m_pend = '0; m_oa = '0; m_ob = '0; m_ov = 1'b0;
        for (int i = 0; i < NR; i++) m_reg[i] = '0;
        forever begin
            @(negedge clk);
            #3;
            rdy = m_ready();
            check("instr_ready", {31'd0, instr_ready}, {31'd0, rdy});
            n_reg = m_reg; n_pend = m_pend; n_oa = m_oa; n_ob = m_ob; n_ov = 1'b0;
            if (rst) begin
                for (int i = 0; i < NR; i++) n_reg[i] = '0;
                n_pend = '0; n_oa = '0; n_ob = '0;
            end else begin
                if (wb_valid) begin
                    n_reg[wb_addr]  = wb_data;
                    n_pend[wb_addr] = 1'b0;
                end
                if (instr_valid && rdy) begin
                    case (op)
                        RD: begin
                            n_oa = m_read(int'(sel_a));
                            n_ob = m_read(int'(sel_b));
                            n_ov = 1'b1;
                            n_pend[sel_d] = 1'b1;
                        end
                        LD: n_reg[sel_d] = imm;
                        MV: n_reg[sel_d] = m_read(int'(sel_a));
                        CL: n_reg[sel_d] = '0;
                        CLA: begin
                            for (int i = 0; i < NR; i++) n_reg[i] = '0;
                            n_pend = '0;
                        end
                        default: ;
                    endcase
                end
            end
            @(posedge clk);
            #1;
            m_reg = n_reg; m_pend = n_pend; m_oa = n_oa; m_ob = n_ob; m_ov = n_ov;
            check("out_a", {24'd0, out_a}, {24'd0, m_oa});
            check("out_b", {24'd0, out_b}, {24'd0, m_ob});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            check("pending", {28'd0, pending}, {28'd0, m_pend});
        end
    end

    task automatic drv(input logic r, input logic e, input logic v, input logic [2:0] o,
                       input int a, input int b, input int d, input logic [DW-1:0] im,
                       input logic wv, input int wa, input logic [DW-1:0] wd);
        @(negedge clk);
        rst = r; en = e; instr_valid = v; op = o;
        sel_a = AW'(a); sel_b = AW'(b); sel_d = AW'(d); imm = im;
        wb_valid = wv; wb_addr = AW'(wa); wb_data = wd;
    endtask

    task automatic instr(input logic [2:0] o, input int a, input int b, input int d,
                         input logic [DW-1:0] im);
        drv(1'b0, 1'b1, 1'b1, o, a, b, d, im, 1'b0, 0, 8'h00);
    endtask

    task automatic wb(input int wa, input logic [DW-1:0] wd);
        drv(1'b0, 1'b1, 1'b0, NOP, 0, 0, 0, 8'h00, 1'b1, wa, wd);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; en = 1'b0; instr_valid = 1'b0; op = NOP;
        sel_a = '0; sel_b = '0; sel_d = '0; imm = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        h_rst = 1'b1; h_en = 1'b0; h_iv = 1'b0; h_op = NOP;
        h_a = '0; h_b = '0; h_d = '0; h_imm = '0; h_wbv = 1'b0; h_wba = '0; h_wbd = '0;

        drv(1'b1, 1'b0, 1'b0, NOP, 0, 0, 0, 8'h00, 1'b0, 0, 8'h00);
        after_edge();
        check("reset out_a", {24'd0, out_a}, 32'h0);
        check("reset out_b", {24'd0, out_b}, 32'h0);
        check("reset out_valid", {31'd0, out_valid}, 32'h0);
        check("reset pending", {28'd0, pending}, 32'h0);

        // Basic load and read with reservation.
        instr(LD, 0, 0, 1, 8'h5A);
        instr(LD, 0, 0, 2, 8'h03);
        instr(RD, 1, 2, 3, 8'h00);
        after_edge();
        check("rd out_a", {24'd0, out_a}, 32'h5A);
        check("rd out_b", {24'd0, out_b}, 32'h03);
        check("rd out_valid", {31'd0, out_valid}, 32'h1);
        check("rd pending", {28'd0, pending}, 32'h8);
        drv(1'b0, 1'b1, 1'b0, NOP, 0, 0, 0, 8'h00, 1'b0, 0, 8'h00);
        after_edge();
        check("out_valid pulse", {31'd0, out_valid}, 32'h0);
        check("out_a hold", {24'd0, out_a}, 32'h5A);

        // Stall on pending source, released by same-cycle write-back with forwarding.
        instr(MV, 3, 0, 0, 8'h00);
        #1 check("mv stalled", {31'd0, instr_ready}, 32'h0);
        drv(1'b0, 1'b1, 1'b1, MV, 3, 0, 0, 8'h00, 1'b1, 3, 8'h77);
        #1 check("mv released", {31'd0, instr_ready}, 32'h1);
        after_edge();
        check("mv pending", {28'd0, pending}, 32'h0);
        instr(RD, 0, 3, 1, 8'h00);
        after_edge();
        check("fwd R0", {24'd0, out_a}, 32'h77);
        check("wb R3", {24'd0, out_b}, 32'h77);
        check("pending R1", {28'd0, pending}, 32'h2);
        wb(1, 8'h22);

        // Disabled: instruction ignored, write-back still lands.
        for (int k = 0; k < 3; k++) begin
            drv(1'b0, 1'b0, 1'b1, LD, 0, 0, 0, 8'hFF, (k == 1), 1, 8'h11);
            #1 check("en low ready", {31'd0, instr_ready}, 32'h0);
        end
        instr(RD, 0, 1, 2, 8'h00);
        after_edge();
        check("en low R0", {24'd0, out_a}, 32'h77);
        check("en low wb R1", {24'd0, out_b}, 32'h11);
        check("pending R2", {28'd0, pending}, 32'h4);

        // Instruction beats write-back to the same register.
        drv(1'b0, 1'b1, 1'b1, LD, 0, 0, 2, 8'hAA, 1'b1, 2, 8'h55);
        #1 check("ld wb ready", {31'd0, instr_ready}, 32'h1);
        after_edge();
        check("ld wb pending", {28'd0, pending}, 32'h0);
        instr(RD, 2, 2, 3, 8'h00);
        after_edge();
        check("ld wins", {24'd0, out_a}, 32'hAA);
        drv(1'b0, 1'b1, 1'b1, RD, 2, 0, 3, 8'h00, 1'b1, 3, 8'h33);
        after_edge();
        check("new reservation wins", {28'd0, pending}, 32'h8);
        check("rd R0", {24'd0, out_b}, 32'h77);

        // Reset discards reservations and overrides instruction and write-back.
        instr(RD, 2, 2, 0, 8'h00);
        instr(RD, 2, 2, 1, 8'h00);
        after_edge();
        check("multi pending", {28'd0, pending}, 32'hB);
        drv(1'b1, 1'b1, 1'b1, LD, 0, 0, 2, 8'hEE, 1'b1, 3, 8'h99);
        after_edge();
        check("rst pending", {28'd0, pending}, 32'h0);
        check("rst out_a", {24'd0, out_a}, 32'h0);
        check("rst out_valid", {31'd0, out_valid}, 32'h0);
        drv(1'b0, 1'b1, 1'b1, RD, 0, 3, 2, 8'h00, 1'b0, 0, 8'h00);
        #1 check("ready after rst", {31'd0, instr_ready}, 32'h1);
        after_edge();
        check("rst R0", {24'd0, out_a}, 32'h0);
        check("rst R3", {24'd0, out_b}, 32'h0);
        wb(0, 8'h44);
        instr(RD, 0, 0, 3, 8'h00);
        after_edge();
        check("wb after rst", {24'd0, out_a}, 32'h44);
        wb(2, 8'h01);
        wb(3, 8'h02);

        // CLEAR and CLEAR_ALL.
        instr(LD, 0, 0, 1, 8'h66);
        instr(CL, 0, 0, 0, 8'h00);
        instr(RD, 0, 1, 2, 8'h00);
        after_edge();
        check("clear R0", {24'd0, out_a}, 32'h0);
        check("load R1", {24'd0, out_b}, 32'h66);
        instr(CLA, 0, 0, 0, 8'h00);
        #1 check("clr_all stalled", {31'd0, instr_ready}, 32'h0);
        wb(2, 8'h05);
        instr(CLA, 0, 0, 0, 8'h00);
        instr(RD, 1, 2, 0, 8'h00);
        after_edge();
        check("clr_all R1", {24'd0, out_a}, 32'h0);
        check("clr_all R2", {24'd0, out_b}, 32'h0);
        check("clr_all pending", {28'd0, pending}, 32'h1);

        // Random traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            drv(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                int'($urandom_range(0, NR - 1)), 8'($urandom),
                ($urandom_range(0, 2) == 0), int'($urandom_range(0, NR - 1)), 8'($urandom));
        end
        drv(1'b0, 1'b1, 1'b0, NOP, 0, 0, 0, 8'h00, 1'b0, 0, 8'h00);

        // Wide instance: 16 registers of 16 bits.
        @(negedge clk);
        h_rst = 1'b0; h_en = 1'b1; h_iv = 1'b1; h_op = LD; h_d = 4'd15; h_imm = 16'hBEEF;
        #1 check("wide ready", {31'd0, h_ready}, 32'h1);
        @(negedge clk);
        h_op = RD; h_a = 4'd15; h_b = 4'd15; h_d = 4'd0;
        @(negedge clk);
        h_iv = 1'b0; h_op = NOP;
        #1;
        check("wide out_a", {16'd0, h_oa}, 32'hBEEF);
        check("wide out_b", {16'd0, h_ob}, 32'hBEEF);
        check("wide out_valid", {31'd0, h_ov}, 32'h1);
        check("wide pending", {16'd0, h_pend}, 32'h0001);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATASIZE, default 8: register and data width in bits.
REQ-002 Parameter NREGS, default 4: number of registers; power of two, 2..16.
REQ-003 Parameter ADDRW, default 2: register-select width; SHALL equal log2(NREGS).
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 en  in  1  main enable; when low, no instruction is accepted.
REQ-007 instr_valid  in  1  instruction present on op/sel_a/sel_b/sel_d/imm.
REQ-008 instr_ready  out  1  block can accept the instruction this cycle (combinational).
REQ-009 op  in  3  opcode: 0 READ_AB, 1 LOAD, 2 MOVE, 3 CLEAR, 4 CLEAR_ALL, 5-7 NOP.
REQ-010 sel_a, sel_b, sel_d  in  ADDRW each  source A, source B, destination register.
REQ-011 imm  in  DATASIZE  immediate for LOAD.
REQ-012 wb_valid  in  1  external write-back (ALU result) present.
REQ-013 wb_addr  in  ADDRW  write-back destination.
REQ-014 wb_data  in  DATASIZE  write-back value.
REQ-015 out_a, out_b  out  DATASIZE  registered operand outputs.
REQ-016 out_valid  out  1  one-cycle pulse: out_a/out_b updated by a READ_AB.
REQ-017 pending  out  NREGS  scoreboard; bit i set = register i awaiting write-back.

Function
REQ-018 Instruction accepted (fires) on a rising edge where instr_valid, instr_ready and en are all high.
REQ-019 instr_ready SHALL be low when en is low, or when any register the instruction reads or writes has its pending bit set and is not cleared by wb this cycle.
REQ-020 Register usage for hazards: READ_AB reads sel_a, sel_b, writes sel_d; LOAD/CLEAR write sel_d; MOVE reads sel_a, writes sel_d; CLEAR_ALL touches all registers; NOP touches none.
REQ-021 READ_AB: out_a <= R[sel_a], out_b <= R[sel_b], out_valid high next cycle, pending[sel_d] set; 1-cycle latency.
REQ-022 LOAD: R[sel_d] <= imm. MOVE: R[sel_d] <= R[sel_a]. CLEAR: R[sel_d] <= 0. CLEAR_ALL: all R <= 0 and all pending <= 0.
REQ-023 Write-back: when wb_valid high, R[wb_addr] <= wb_data and pending[wb_addr] cleared, independent of en.
REQ-024 Forwarding: if a firing READ_AB or MOVE reads wb_addr while wb_valid is high, it SHALL use wb_data, not the stale register.
REQ-025 Same-cycle write to one register by instruction and wb: instruction value wins; pending bit is then set only if instruction is READ_AB with that sel_d.
REQ-026 READ_AB with sel_d equal to wb_addr in the same cycle: pending[sel_d] ends set (new reservation wins).
REQ-027 wb_valid to a non-pending register SHALL still write the register.
REQ-028 Multiple registers may be pending simultaneously; no limit other than NREGS.
REQ-029 out_a/out_b hold value between READ_AB instructions; out_valid low otherwise.
REQ-030 No arithmetic; all values pass at full DATASIZE width, no truncation.

Reset
REQ-031 With rst high at a rising edge: all registers, out_a, out_b, out_valid, pending <= 0; rst overrides any firing instruction and wb.
REQ-032 Reset mid-operation discards outstanding reservations; a later wb_valid to a previously pending register just writes it.
REQ-033 instr_ready SHALL reflect the cleared scoreboard in the cycle after reset.

Verification
REQ-034 LOAD R1=0x5A, LOAD R2=0x03, READ_AB a=1 b=2 d=3 -> next cycle out_a=0x5A, out_b=0x03, out_valid=1 for one cycle, pending=4'b1000.
REQ-035 With R3 pending, present MOVE a=3 d=0 -> instr_ready=0; assert wb_valid addr=3 data=0x77 -> MOVE fires that cycle, R0=0x77 (forwarded), pending=0.
REQ-036 en=0 with valid LOAD R0=0xFF held 3 cycles -> R0 unchanged, instr_ready=0; wb_valid addr=1 data=0x11 during that time -> R1=0x11.
REQ-037 LOAD R2=0xAA and wb_valid addr=2 data=0x55 same cycle -> R2=0xAA.
REQ-038 R0,R1 pending, rst pulsed 1 cycle -> all registers 0, pending=0, out_a=out_b=0, instr_ready=1 with en high.
REQ-039 NREGS=16, DATASIZE=16: LOAD R15=0xBEEF, READ_AB a=15 b=15 d=0 -> out_a=out_b=0xBEEF, pending=16'h0001.
